// File: rtl/audio_fir_mc.sv
// Multichannel audio FIR with one time-shared signed multiplier.
// Every accepted frame is filtered channel by channel, then rounded, saturated and emitted as a single frame.
module audio_fir_mc #(
  parameter int DATA_WIDTH   = 24,
  parameter int COEFF_WIDTH  = 16,
  parameter int COEFF_FRAC   = 15,
  parameter int NUM_TAPS     = 64,
  parameter int NUM_CHANNELS = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   data_in,
  input  logic                                 data_in_valid,
  output logic                                 data_in_ready,
  input  logic                                 bypass,
  input  logic                                 coeff_wr_en,
  input  logic [$clog2(NUM_TAPS)-1:0]          coeff_wr_addr,
  input  logic [COEFF_WIDTH-1:0]               coeff_wr_data,
  output logic                                 coeff_wr_err,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   data_out,
  output logic                                 data_out_valid,
  output logic                                 sat_flag
);

  localparam int DW    = DATA_WIDTH;
  localparam int CW    = COEFF_WIDTH;
  localparam int NC    = NUM_CHANNELS;
  localparam int TAPW  = $clog2(NUM_TAPS);
  localparam int CHW   = (NC > 1) ? $clog2(NC) : 1;
  localparam int NPROD = NC * NUM_TAPS;
  localparam int CNTW  = $clog2(NPROD + 1);
  localparam int PW    = DW + CW;
  localparam int AW    = DW + CW + TAPW;

  localparam logic [CNTW-1:0]      CNT_MAC_LAST = CNTW'(NPROD);
  localparam logic [CNTW-1:0]      CNT_CLR_LAST = CNTW'(NUM_TAPS - 1);
  localparam logic signed [AW-1:0] RND_BIAS     = AW'(1) << (COEFF_FRAC - 1);
  localparam logic signed [AW-1:0] SAT_MAX      = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN      = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_MAC, S_OUT} state_t;

  state_t                   r_state;
  logic [CNTW-1:0]          r_cnt;
  logic                     r_ready;
  logic [TAPW-1:0]          r_wr_ptr;
  logic                     r_bypass;
  logic [NC*DW-1:0]         r_frame;
  logic signed [PW-1:0]     r_prod;
  logic                     r_prod_vld;
  logic [CHW-1:0]           r_prod_ch;
  logic signed [AW-1:0]     r_acc [NC];
  logic [NC*DW-1:0]         r_data_out;
  logic                     r_valid;
  logic                     r_sat;
  logic                     r_wr_err;
  logic signed [CW-1:0]     r_coeff [NUM_TAPS];
  logic signed [DW-1:0]     r_hist [NC][NUM_TAPS];

  logic                     w_accept;
  logic [TAPW-1:0]          w_tap;
  logic [CHW-1:0]           w_ch;
  logic [TAPW-1:0]          w_rd_addr;
  logic signed [DW-1:0]     w_hist_op;
  logic signed [CW-1:0]     w_coeff_op;
  logic                     w_hist_we;
  logic [TAPW-1:0]          w_hist_addr;
  logic [NC*DW-1:0]         w_hist_wdata;
  logic signed [AW-1:0]     w_rnd;
  logic [NC*DW-1:0]         w_out;
  logic                     w_sat_any;

  assign w_accept   = (r_state == S_IDLE) && data_in_valid;
  assign w_tap      = r_cnt[TAPW-1:0];
  assign w_ch       = CHW'(r_cnt >> TAPW);
  // Tap 0 is the newest sample, so taps walk backwards around the circular history.
  assign w_rd_addr  = r_wr_ptr - w_tap;
  assign w_hist_op  = r_hist[w_ch][w_rd_addr];
  assign w_coeff_op = r_coeff[w_tap];

  assign w_hist_we    = (r_state == S_CLEAR) || w_accept;
  assign w_hist_addr  = (r_state == S_CLEAR) ? r_cnt[TAPW-1:0] : r_wr_ptr;
  assign w_hist_wdata = (r_state == S_CLEAR) ? '0 : data_in;

  // NOTE: the history RAM has no reset; CLEAR zeroes it one address per cycle after release.
  always_ff @(posedge clk) begin
    if (w_hist_we) begin
      for (int c = 0; c < NC; c++) begin
        r_hist[c][w_hist_addr] <= w_hist_wdata[c*DW +: DW];
      end
    end
  end

  // A write is applied on the IDLE edge itself, so a frame accepted on that edge uses it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coeff  <= '{default: '0};
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= coeff_wr_en && (r_state != S_IDLE);
      if (coeff_wr_en && (r_state == S_IDLE)) begin
        r_coeff[coeff_wr_addr] <= coeff_wr_data;
      end
    end
  end

  always_comb begin
    w_out     = '0;
    w_sat_any = 1'b0;
    w_rnd     = '0;
    for (int c = 0; c < NC; c++) begin
      w_rnd = (r_acc[c] + RND_BIAS) >>> COEFF_FRAC;
      if (w_rnd > SAT_MAX) begin
        w_out[c*DW +: DW] = SAT_MAX[DW-1:0];
        w_sat_any         = 1'b1;
      end else if (w_rnd < SAT_MIN) begin
        w_out[c*DW +: DW] = SAT_MIN[DW-1:0];
        w_sat_any         = 1'b1;
      end else begin
        w_out[c*DW +: DW] = w_rnd[DW-1:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_CLEAR;
      r_cnt      <= '0;
      r_ready    <= 1'b0;
      r_wr_ptr   <= '0;
      r_bypass   <= 1'b0;
      r_frame    <= '0;
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
      r_prod_ch  <= '0;
      r_acc      <= '{default: '0};
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_sat      <= 1'b0;
    end else begin
      r_valid    <= 1'b0;
      r_prod_vld <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          if (r_cnt == CNT_CLR_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (data_in_valid) begin
            r_state  <= S_MAC;
            r_ready  <= 1'b0;
            r_bypass <= bypass;
            r_frame  <= data_in;
            r_cnt    <= '0;
          end
        end
        S_MAC: begin
          if (r_cnt < CNT_MAC_LAST) begin
            r_prod     <= w_hist_op * w_coeff_op;
            r_prod_vld <= 1'b1;
            r_prod_ch  <= w_ch;
            if (w_tap == '0) r_acc[w_ch] <= '0;
          end
          // The extra cycle at CNT_MAC_LAST drains the product register into its accumulator.
          if (r_cnt == CNT_MAC_LAST) begin
            r_state <= S_OUT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_OUT: begin
          r_data_out <= r_bypass ? r_frame : w_out;
          r_sat      <= r_bypass ? 1'b0 : w_sat_any;
          r_valid    <= 1'b1;
          r_wr_ptr   <= r_wr_ptr + 1'b1;
          r_state    <= S_IDLE;
          r_ready    <= 1'b1;
        end
        default: r_state <= S_CLEAR;
      endcase
      // Never collides with the clear above: a channel's first product is issued while the previous channel drains.
      if (r_prod_vld) begin
        r_acc[r_prod_ch] <= r_acc[r_prod_ch] + {{(AW-PW){r_prod[PW-1]}}, r_prod};
      end
    end
  end

  assign data_in_ready  = r_ready;
  assign data_out       = r_data_out;
  assign data_out_valid = r_valid;
  assign sat_flag       = r_sat;
  assign coeff_wr_err   = r_wr_err;

endmodule
